// File: rtl/ex_muldiv_seq_pkg.sv
// Shared types for the multi-cycle M-extension sequencer beside the EX-stage ALU.
package ex_muldiv_seq_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 7;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_BUSY,
    MDU_DONE
  } mdu_state_e;

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// EX-stage <-> M-extension sequencer handshake bundle.
interface ex_muldiv_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            valid_i;
  logic [2:0]      funct3_i;
  logic            is_word_op_i;
  logic [XLEN-1:0] src_a_i;
  logic [XLEN-1:0] src_b_i;
  logic            flush_i;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, funct3_i, is_word_op_i, src_a_i, src_b_i, flush_i,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  valid_i, funct3_i, is_word_op_i, src_a_i, src_b_i, flush_i,
    output stall_o, done_o, result_o
  );
endinterface

// File: rtl/ex_muldiv_seq_divstep.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract divisor, set quotient bit.
module ex_muldiv_seq_divstep #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  assign w_shift = {i_rem, i_quo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, i_divisor});
  // When w_ge the true difference is below the divisor, so the low XLEN bits are exact.
  assign w_diff  = w_shift[XLEN-1:0] - i_divisor;
  assign o_rem   = w_ge ? w_diff : w_shift[XLEN-1:0];
  assign o_quo   = {i_quo[XLEN-2:0], w_ge};
endmodule

// File: rtl/ex_muldiv_seq.sv
// Iterative shift-add MUL/MULH* and restoring DIV/REM sequencer; owns the EX stall for M ops.
// Optional MDU_EARLY_OUT_EN: trivial operands (div by zero, signed overflow, zero mul operand) skip BUSY.
module ex_muldiv_seq
  import ex_muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  ex_muldiv_seq_if.slave bus
);
  localparam int unsigned PW   = 2 * XLEN;
  localparam bit          W_EN = (XLEN == 64);

  mdu_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  mdu_op_e          r_op;
  logic             r_word, r_neg, r_special;
  logic [XLEN-1:0]  r_spec_res, r_mplier;
  logic [PW-1:0]    r_acc, r_mcand;

  mdu_op_e          w_op;
  logic             w_word, w_accept, w_is_div, w_is_rem, w_a_sgn, w_b_sgn, w_neg;
  logic             w_b_zero, w_ovf, w_div_special, w_early;
  logic signed [WORD_W-1:0] w_a_lo, w_b_lo, w_raw_lo;
  logic [XLEN-1:0]  w_a_ext, w_b_ext, w_a_neg, w_b_neg, w_a_mag, w_b_mag, w_a_align;
  logic [XLEN-1:0]  w_min, w_spec_res, w_rem_nxt, w_quo_nxt;
  logic [CNT_W-1:0] w_n;

  // Operand decode at accept: sign-extend word ops, take magnitudes over N bits.
  assign w_op      = mdu_op_e'(bus.funct3_i);
  assign w_word    = W_EN & bus.is_word_op_i;
  assign w_a_lo    = bus.src_a_i[WORD_W-1:0];
  assign w_b_lo    = bus.src_b_i[WORD_W-1:0];
  assign w_a_ext   = w_word ? XLEN'(w_a_lo) : bus.src_a_i;
  assign w_b_ext   = w_word ? XLEN'(w_b_lo) : bus.src_b_i;
  assign w_is_div  = w_op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  assign w_is_rem  = w_op inside {MDU_REM, MDU_REMU};
  assign w_a_sgn   = (w_op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM}) & w_a_ext[XLEN-1];
  assign w_b_sgn   = (w_op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM}) & w_b_ext[XLEN-1];
  assign w_neg     = w_is_rem ? w_a_sgn : (w_a_sgn ^ w_b_sgn);
  assign w_a_neg   = w_a_sgn ? -w_a_ext : w_a_ext;
  assign w_b_neg   = w_b_sgn ? -w_b_ext : w_b_ext;
  assign w_a_mag   = w_word ? (w_a_neg & XLEN'(32'hFFFF_FFFF)) : w_a_neg;
  assign w_b_mag   = w_word ? (w_b_neg & XLEN'(32'hFFFF_FFFF)) : w_b_neg;
  assign w_a_align = w_word ? (w_a_mag << (XLEN - WORD_W)) : w_a_mag;
  assign w_n       = w_word ? CNT_W'(WORD_W) : CNT_W'(XLEN);
  assign w_min     = w_word ? ~XLEN'(32'h7FFF_FFFF) : (XLEN'(1) << (XLEN - 1));

  assign w_b_zero      = (w_b_ext == '0);
  assign w_ovf         = (w_op inside {MDU_DIV, MDU_REM}) & (w_b_ext == '1) & (w_a_ext == w_min);
  assign w_div_special = w_is_div & (w_b_zero | w_ovf);
  assign w_spec_res    = !w_div_special ? '0 :
                         w_b_zero ? (w_is_rem ? w_a_ext : '1) :
                                    (w_is_rem ? '0 : w_a_ext);

`ifdef MDU_EARLY_OUT_EN
  logic w_mul_zero;
  assign w_mul_zero = !w_is_div & ((w_a_mag == '0) | (w_b_mag == '0));
  assign w_early    = w_div_special | w_mul_zero;
`else
  assign w_early    = 1'b0;
`endif

  assign w_accept = (r_state == MDU_IDLE) & bus.valid_i & !bus.flush_i;

  ex_muldiv_seq_divstep #(.XLEN(XLEN)) u_divstep (
    .i_rem     (r_acc[PW-1:XLEN]),
    .i_quo     (r_acc[XLEN-1:0]),
    .i_divisor (r_mcand[XLEN-1:0]),
    .o_rem     (w_rem_nxt),
    .o_quo     (w_quo_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= MDU_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MDU_IDLE: if (w_accept) w_state_nxt = w_early ? MDU_DONE : MDU_BUSY;
      MDU_BUSY: if (r_cnt == CNT_W'(1)) w_state_nxt = MDU_DONE;
      MDU_DONE: w_state_nxt = MDU_IDLE;
      default:  w_state_nxt = MDU_IDLE;
    endcase
    if (bus.flush_i) w_state_nxt = MDU_IDLE;
  end

  // Datapath: latch at accept, one bit per BUSY cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_op       <= MDU_MUL;
      r_word     <= 1'b0;
      r_neg      <= 1'b0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
    end else if (bus.flush_i) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        MDU_IDLE: if (w_accept) begin
          r_cnt      <= w_n;
          r_op       <= w_op;
          r_word     <= w_word;
          r_neg      <= w_neg;
          r_special  <= w_div_special | w_early;
          r_spec_res <= w_spec_res;
          r_mplier   <= w_b_mag;
          r_mcand    <= w_is_div ? PW'(w_b_mag) : PW'(w_a_mag);
          r_acc      <= w_is_div ? PW'(w_a_align) : '0;
        end
        MDU_BUSY: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_op[2]) begin
            r_acc <= {w_rem_nxt, w_quo_nxt};
          end else begin
            r_acc    <= r_acc + (r_mplier[0] ? r_mcand : PW'(0));
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
        end
        MDU_DONE: r_cnt <= '0;
        default:  r_cnt <= '0;
      endcase
    end
  end

  logic            w_r_is_rem;
  logic [PW-1:0]   w_prod;
  logic [XLEN-1:0] w_qr, w_mul_hi, w_raw, w_final;

  // Sign fix and selection of the final value presented on the DONE cycle.
  assign w_r_is_rem = r_op inside {MDU_REM, MDU_REMU};
  assign w_prod     = r_neg ? -r_acc : r_acc;
  assign w_qr       = w_r_is_rem ? r_acc[PW-1:XLEN] : r_acc[XLEN-1:0];
  assign w_mul_hi   = r_word ? XLEN'(w_prod[63:32]) : w_prod[PW-1:XLEN];
  assign w_raw      = r_op[2] ? (r_neg ? -w_qr : w_qr) :
                      (r_op == MDU_MUL) ? w_prod[XLEN-1:0] : w_mul_hi;
  assign w_raw_lo   = w_raw[WORD_W-1:0];
  assign w_final    = r_special ? r_spec_res : (r_word ? XLEN'(w_raw_lo) : w_raw);

  always_comb begin
    bus.stall_o  = 1'b0;
    bus.done_o   = 1'b0;
    bus.result_o = '0;
    if (!reset) begin
      bus.stall_o = w_accept | (r_state == MDU_BUSY);
      if ((r_state == MDU_DONE) && !bus.flush_i) begin
        bus.done_o   = 1'b1;
        bus.result_o = w_final;
      end
    end
  end

endmodule
